// File: rtl/key_pkg.sv
// Shared constants and state encoding for the push-button debouncer.
package key_pkg;

  localparam int unsigned CLK_FREQ_HZ = 50_000_000;
  // 10 ms of stable level at the board clock.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_FREQ_HZ / 100;

  typedef enum logic {
    StIdle  = 1'b0,
    StCount = 1'b1
  } key_state_e;

endpackage

// File: rtl/key_debounce_bit.sv
// One debounce channel: 2-FF synchronizer, stability counter, registered level and edge strobes.
module key_debounce_bit
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit          RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_in,
  output logic key_out,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_q, key_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
      state_q <= StIdle;
      cnt_q   <= '0;
      key_q   <= RESET_LEVEL;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (sync2_q != key_q) begin
          state_d = StCount;
          cnt_d   = CNT_W'(1);
        end
      end
      StCount: begin
        if (sync2_q == key_q) begin
          // Bounced back before the level proved stable: drop the attempt silently.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = StIdle;
          cnt_d   = '0;
          key_d   = sync2_q;
          press_d = ~sync2_q;
          rel_d   = sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign key_out       = key_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;

endmodule

// File: rtl/key_debounce.sv
// Debouncer for a bank of active-low push buttons; one independent channel per key.
module key_debounce #(
  parameter int unsigned N_KEYS          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = key_pkg::DEBOUNCE_CYCLES_DEF,
  parameter bit          RESET_LEVEL     = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_out,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL)
    ) u_bit (
      .clk           (clk),
      .reset_n       (reset_n),
      .key_in        (key_in[i]),
      .key_out       (key_out[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule
